// File: rtl/mem_bridge.sv
// mem_bridge: converts the control FSM's mem_read / mem_write requests into a
// single valid/ack bus transaction. Handles byte-lane steering, byte enables,
// load sign/zero extension, alignment checking and a bus-ack timeout.
module mem_bridge #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mar,
    input  logic [31:0] mdr,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_REQ,
        S_RESP,
        S_HOLD
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_t            state_q, state_d;
    logic              wr_q, wr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        ofs_q, ofs_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_resp_q, mem_resp_d;
    logic              mem_err_q, mem_err_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [31:0]       bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;

    // Decoded view of the live request while in SETUP
    logic              setup_legal;
    logic [3:0]        setup_be;
    logic [31:0]       setup_wdata;

    // Aligned and extended load data for the captured access
    logic [31:0]       rd_shifted;
    logic [31:0]       load_data;

    // Size/alignment legality, byte enables and replicated store data from live funct3/mar/mdr
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        setup_legal = 1'b0;
        setup_be    = 4'b0000;
        setup_wdata = 32'h0;
        case (mem_funct3)
            3'b000, 3'b100: begin
                setup_legal = !(wr_q && mem_funct3[2]);
                setup_be    = 4'b0001 << mar[1:0];
                setup_wdata = {4{mdr[7:0]}};
            end
            3'b001, 3'b101: begin
                setup_legal = !mar[0] && !(wr_q && mem_funct3[2]);
                setup_be    = 4'b0011 << mar[1:0];
                setup_wdata = {2{mdr[15:0]}};
            end
            3'b010: begin
                setup_legal = (mar[1:0] == 2'b00);
                setup_be    = 4'hF;
                setup_wdata = mdr;
            end
            default: begin
                setup_legal = 1'b0;
            end
        endcase
    end

    // Shift the addressed lane down to bit 0 and extend according to the load type
    always_comb begin
        rd_shifted = bus_rdata >> {ofs_q, 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b100:  load_data = {24'h0, rd_shifted[7:0]};
            3'b001:  load_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b101:  load_data = {16'h0, rd_shifted[15:0]};
            default: load_data = rd_shifted;
        endcase
    end

    // Next-state and next-register values for the transaction FSM
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        funct3_d    = funct3_q;
        ofs_d       = ofs_q;
        cnt_d       = cnt_q;
        mem_resp_d  = 1'b0;
        mem_err_d   = mem_err_q;
        mem_rdata_d = mem_rdata_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;

        case (state_q)
            S_IDLE: begin
                // Write wins when both requests are present; the write may be a one-cycle pulse.
                if (mem_write || mem_read) begin
                    state_d     = S_SETUP;
                    wr_d        = mem_write;
                    mem_err_d   = 1'b0;
                    mem_rdata_d = 32'h0;
                end
            end
            S_SETUP: begin
                // mar/mdr are sampled here, one cycle after the request, so a MAR loaded
                // alongside the request edge is already valid.
                funct3_d = mem_funct3;
                ofs_d    = mar[1:0];
                if (setup_legal) begin
                    state_d     = S_REQ;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = wr_q;
                    bus_addr_d  = {mar[31:2], 2'b00};
                    bus_be_d    = setup_be;
                    bus_wdata_d = setup_wdata;
                end else begin
                    state_d    = S_RESP;
                    mem_resp_d = 1'b1;
                    mem_err_d  = 1'b1;
                end
            end
            S_REQ: begin
                // An ack in the final timeout cycle still completes the access without error.
                if (bus_ack) begin
                    state_d     = S_RESP;
                    mem_resp_d  = 1'b1;
                    mem_err_d   = 1'b0;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_be_d    = 4'b0000;
                    if (!wr_q) begin
                        mem_rdata_d = load_data;
                    end
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    state_d    = S_RESP;
                    mem_resp_d = 1'b1;
                    mem_err_d  = 1'b1;
                    bus_req_d  = 1'b0;
                    bus_we_d   = 1'b0;
                    bus_be_d   = 4'b0000;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                // A request level still held from this access must not start another one.
                if (!mem_read && !mem_write) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops bus_req immediately without waiting for ack
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all state is reset and updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_q        <= 1'b0;
            funct3_q    <= 3'b000;
            ofs_q       <= 2'b00;
            cnt_q       <= '0;
            mem_resp_q  <= 1'b0;
            mem_err_q   <= 1'b0;
            mem_rdata_q <= 32'h0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            funct3_q    <= funct3_d;
            ofs_q       <= ofs_d;
            cnt_q       <= cnt_d;
            mem_resp_q  <= mem_resp_d;
            mem_err_q   <= mem_err_d;
            mem_rdata_q <= mem_rdata_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign mem_resp  = mem_resp_q;
    assign mem_err   = mem_err_q;
    assign mem_rdata = mem_rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Testbench for mem_bridge: table of directed accesses, randomized accesses
// against a byte-level reference model, and hand sequences for reset and
// simultaneous read/write requests.
module tb_mem_bridge;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] mar, mdr;
    logic        mem_resp, mem_err;
    logic [31:0] mem_rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_bridge #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
        .mar(mar), .mdr(mdr),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        legal;
        logic        err;
        int          resp_cycle;
        int          req_cycles;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        int          resp_cycle;
        int          resp_count;
        int          req_cycles;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] rdata_late;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        stable;
    } obs_t;

    typedef struct {
        string       name;
        logic        is_wr;
        logic [2:0]  f3;
        logic [31:0] mar;
        logic [31:0] mdr;
        int          wait_n;
        logic [31:0] rd;
        exp_t        e;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: works byte by byte from the access rules
    function automatic exp_t model(input logic is_wr, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wd, input int wait_n, input logic [31:0] rd);
        exp_t   e;
        int     nb;
        int     a;
        bit     sgn;
        bit     ok;
        longint val;
        a   = int'(addr[1:0]);
        nb  = 1;
        sgn = 1'b0;
        ok  = 1'b1;
        case (f3)
            3'd0: begin nb = 1; sgn = 1'b1; end
            3'd1: begin nb = 2; sgn = 1'b1; end
            3'd2: begin nb = 4; end
            3'd4: begin nb = 1; ok = !is_wr; end
            3'd5: begin nb = 2; ok = !is_wr; end
            default: ok = 1'b0;
        endcase
        if ((a % nb) != 0) ok = 1'b0;
        e.legal = ok;
        e.we    = is_wr;
        e.addr  = addr & 32'hFFFF_FFFC;
        if (!ok) begin
            e.err = 1'b1; e.resp_cycle = 2; e.req_cycles = 0;
        end else if (wait_n < T) begin
            e.err = 1'b0; e.resp_cycle = 3 + wait_n; e.req_cycles = wait_n + 1;
        end else begin
            e.err = 1'b1; e.resp_cycle = 2 + T; e.req_cycles = T;
        end
        e.be = 4'b0000;
        for (int i = 0; i < nb; i++) if (a + i < 4) e.be[a + i] = 1'b1;
        e.wdata = 32'h0;
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
        val = 0;
        for (int i = 0; i < nb; i++) if (a + i < 4) val = val | (longint'(rd[8*(a+i) +: 8]) << (8*i));
        if (sgn && val[8*nb-1]) val = val - (longint'(1) << (8*nb));
        e.rdata = val[31:0];
        return e;
    endfunction

    // Drives one access, plays the bus slave and records what the DUT did
    task automatic run_access(input logic is_wr, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input int wait_n, input logic [31:0] rd,
                              output obs_t o);
        int n_req;
        o.resp_cycle = -1; o.resp_count = 0; o.req_cycles = 0; o.err = 1'b0;
        o.rdata = 32'h0; o.rdata_late = 32'h0; o.addr = 32'h0; o.be = 4'h0;
        o.we = 1'b0; o.wdata = 32'h0; o.stable = 1'b1;
        n_req = 0;
        mem_funct3 = f3; mar = addr; mdr = wd; bus_ack = 1'b0;
        if (is_wr) mem_write = 1'b1; else mem_read = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 1 && is_wr) mem_write = 1'b0;
            if (c == 2) begin mar = $urandom; mdr = $urandom; end
            if (bus_req) begin
                if (n_req == 0) begin
                    o.addr = bus_addr; o.be = bus_be; o.we = bus_we; o.wdata = bus_wdata;
                end else if (bus_addr !== o.addr || bus_be !== o.be || bus_we !== o.we || bus_wdata !== o.wdata) begin
                    o.stable = 1'b0;
                end
                n_req++;
            end
            if (mem_resp) begin
                o.resp_count++;
                if (o.resp_cycle < 0) begin
                    o.resp_cycle = c; o.err = mem_err; o.rdata = mem_rdata;
                end
            end
            bus_ack   = bus_req && (n_req - 1 == wait_n);
            bus_rdata = bus_ack ? rd : $urandom;
            if (o.resp_cycle >= 0 && c >= o.resp_cycle + 3) break;
        end
        o.req_cycles = n_req;
        o.rdata_late = mem_rdata;
        mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
        tick();
        tick();
    endtask

    task automatic compare(input string tag, input obs_t o, input exp_t e, input logic is_wr);
        check($sformatf("%s resp_cycle", tag), o.resp_cycle, e.resp_cycle);
        check($sformatf("%s resp_count", tag), o.resp_count, 1);
        check($sformatf("%s err", tag), {31'h0, o.err}, {31'h0, e.err});
        check($sformatf("%s req_cycles", tag), o.req_cycles, e.req_cycles);
        if (e.legal) begin
            check($sformatf("%s addr", tag), o.addr, e.addr);
            check($sformatf("%s be", tag), {28'h0, o.be}, {28'h0, e.be});
            check($sformatf("%s we", tag), {31'h0, o.we}, {31'h0, e.we});
            check($sformatf("%s stable", tag), {31'h0, o.stable}, 32'h1);
            if (is_wr) begin
                check($sformatf("%s wdata", tag), o.wdata, e.wdata);
            end else if (!e.err) begin
                check($sformatf("%s rdata", tag), o.rdata, e.rdata);
                check($sformatf("%s rdata_held", tag), o.rdata_late, e.rdata);
            end
        end
    endtask

    function automatic exp_t mk(input logic legal, input logic err, input int rc, input int rq,
                                input logic [31:0] addr, input logic [3:0] be, input logic we,
                                input logic [31:0] wdata, input logic [31:0] rdata);
        exp_t e;
        e.legal = legal; e.err = err; e.resp_cycle = rc; e.req_cycles = rq;
        e.addr = addr; e.be = be; e.we = we; e.wdata = wdata; e.rdata = rdata;
        return e;
    endfunction

    vec_t vecs[15];
    obs_t o;
    exp_t e;

    initial begin
        vecs[0]  = '{"lw_wait2",    1'b0, 3'b010, 32'h100, 32'h0,        2,   32'hDEADBEEF, mk(1,0,5,3, 32'h100,4'hF,0,32'h0,32'hDEADBEEF)};
        vecs[1]  = '{"lb_103",      1'b0, 3'b000, 32'h103, 32'h0,        0,   32'h80FF0000, mk(1,0,3,1, 32'h100,4'b1000,0,32'h0,32'hFFFFFF80)};
        vecs[2]  = '{"lbu_103",     1'b0, 3'b100, 32'h103, 32'h0,        0,   32'h80FF0000, mk(1,0,3,1, 32'h100,4'b1000,0,32'h0,32'h00000080)};
        vecs[3]  = '{"sh_202",      1'b1, 3'b001, 32'h202, 32'h1234ABCD, 0,   32'h0,        mk(1,0,3,1, 32'h200,4'b1100,1,32'hABCDABCD,32'h0)};
        vecs[4]  = '{"sw_misalign", 1'b1, 3'b010, 32'h101, 32'h0,        0,   32'h0,        mk(0,1,2,0, 32'h0,4'h0,1,32'h0,32'h0)};
        vecs[5]  = '{"lw_timeout",  1'b0, 3'b010, 32'h400, 32'h0,        100, 32'h0,        mk(1,1,10,8, 32'h400,4'hF,0,32'h0,32'h0)};
        vecs[6]  = '{"lw_ack_last", 1'b0, 3'b010, 32'h404, 32'h0,        7,   32'h12345678, mk(1,0,10,8, 32'h404,4'hF,0,32'h0,32'h12345678)};
        vecs[7]  = '{"lh_102",      1'b0, 3'b001, 32'h102, 32'h0,        1,   32'h80015555, mk(1,0,4,2, 32'h100,4'b1100,0,32'h0,32'hFFFF8001)};
        vecs[8]  = '{"lhu_106",     1'b0, 3'b101, 32'h106, 32'h0,        0,   32'h80015555, mk(1,0,3,1, 32'h104,4'b1100,0,32'h0,32'h00008001)};
        vecs[9]  = '{"lh_misalign", 1'b0, 3'b001, 32'h101, 32'h0,        0,   32'h0,        mk(0,1,2,0, 32'h0,4'h0,0,32'h0,32'h0)};
        vecs[10] = '{"rd_f3_011",   1'b0, 3'b011, 32'h0,   32'h0,        0,   32'h0,        mk(0,1,2,0, 32'h0,4'h0,0,32'h0,32'h0)};
        vecs[11] = '{"wr_f3_100",   1'b1, 3'b100, 32'h0,   32'h0,        0,   32'h0,        mk(0,1,2,0, 32'h0,4'h0,1,32'h0,32'h0)};
        vecs[12] = '{"sb_001",      1'b1, 3'b000, 32'h1,   32'h000000AB, 3,   32'h0,        mk(1,0,6,4, 32'h0,4'b0010,1,32'hABABABAB,32'h0)};
        vecs[13] = '{"lb_pos",      1'b0, 3'b000, 32'h1,   32'h0,        0,   32'h00007F00, mk(1,0,3,1, 32'h0,4'b0010,0,32'h0,32'h0000007F)};
        vecs[14] = '{"rd_f3_110",   1'b0, 3'b110, 32'h8,   32'h0,        0,   32'h0,        mk(0,1,2,0, 32'h0,4'h0,0,32'h0,32'h0)};

        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_funct3 = 3'b000;
        mar = 32'h0; mdr = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        tick();
        tick();
        check("reset ctl", {27'h0, bus_req, mem_resp, mem_err, bus_we, 1'b0}, 32'h0);
        check("reset be", {28'h0, bus_be}, 32'h0);
        check("reset addr", bus_addr, 32'h0);
        check("reset wdata", bus_wdata, 32'h0);
        check("reset rdata", mem_rdata, 32'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 15; i++) begin
            run_access(vecs[i].is_wr, vecs[i].f3, vecs[i].mar, vecs[i].mdr, vecs[i].wait_n, vecs[i].rd, o);
            compare(vecs[i].name, o, vecs[i].e, vecs[i].is_wr);
        end

        for (int i = 0; i < 60; i++) begin
            logic        w;
            logic [2:0]  f;
            logic [31:0] ad, wd, rd;
            int          wn;
            w  = 1'($urandom_range(0, 1));
            f  = 3'($urandom_range(0, 7));
            ad = $urandom;
            wd = $urandom;
            rd = $urandom;
            wn = $urandom_range(0, 10);
            e  = model(w, f, ad, wd, wn, rd);
            run_access(w, f, ad, wd, wn, rd, o);
            compare($sformatf("rand%0d", i), o, e, w);
        end

        // Both requests high: the write wins; the held read must not retrigger afterwards
        mem_read = 1'b1; mem_write = 1'b1; mem_funct3 = 3'b010; mar = 32'h300; mdr = 32'h55AA55AA;
        tick();
        mem_write = 1'b0;
        tick();
        check("both bus_req", {31'h0, bus_req}, 32'h1);
        check("both bus_we", {31'h0, bus_we}, 32'h1);
        check("both wdata", bus_wdata, 32'h55AA55AA);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("both resp", {30'h0, mem_resp, mem_err}, 32'h2);
        tick();
        tick();
        tick();
        check("both no_retrigger", {30'h0, bus_req, mem_resp}, 32'h0);
        mem_read = 1'b0;
        tick();
        tick();

        // Reset in the middle of REQ, then a held mem_read starts a fresh access
        mem_read = 1'b1; mem_funct3 = 3'b010; mar = 32'h500;
        tick();
        tick();
        check("rst_mid bus_req_before", {31'h0, bus_req}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid async", {29'h0, bus_req, mem_resp, mem_err}, 32'h0);
        check("rst_mid rdata", mem_rdata, 32'h0);
        tick();
        rst_n = 1'b1;
        mar = 32'h504;
        tick();
        check("rst_mid setup no_req", {31'h0, bus_req}, 32'h0);
        tick();
        check("rst_mid new req", {31'h0, bus_req}, 32'h1);
        check("rst_mid new addr", bus_addr, 32'h504);
        bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        tick();
        bus_ack = 1'b0;
        check("rst_mid resp", {30'h0, mem_resp, mem_err}, 32'h2);
        check("rst_mid rdata_new", mem_rdata, 32'hCAFEF00D);
        mem_read = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
